button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Consumes the debounced, active-high level of one push button and turns it into single-cycle event pulses: press, release, short click, long press, auto-repeat while held and, optionally, double click. It sits directly downstream of the button debouncer. Its pulses drive the UI control FSMs, so those FSMs never handle raw levels or timing.

## Interface
- CLK_PERIOD_NS, default 10: clock period; converts all ms parameters to cycles as `MS*1_000_000/CLK_PERIOD_NS`, using integer elaboration math.
- LONG_PRESS_MS, default 1000: hold time before `long_out`. Call the cycle count LONG_CYC; LONG_CYC ≥ 2.
- REPEAT_PERIOD_MS, default 100: spacing of `repeat_out` pulses after a long press. Cycle count REP_CYC; REP_CYC ≥ 2.
- DOUBLE_GAP_MS, default 250: maximum release-to-press gap for a double click. Cycle count GAP_CYC; GAP_CYC ≥ 2; used only with the macro.
- clk_in  input  1  system clock. One clock domain only.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- clean_in  input  1  debounced button level, 1 = pressed; synchronous to clk_in.
- press_out  output  1  one-cycle pulse on each rising edge of `clean_in`.
- release_out  output  1  one-cycle pulse on each falling edge of `clean_in`.
- short_out  output  1  one-cycle pulse for a click released before LONG_CYC.
- long_out  output  1  one-cycle pulse when the hold reaches LONG_CYC.
- repeat_out  output  1  one-cycle pulse every REP_CYC cycles after `long_out` while the button stays held.
- double_out  output  1  one-cycle double-click pulse. Tied 0 without the macro.
- held_out  output  1  registered copy of the pressed state.

## Operation
- Input register `in_q` samples `clean_in` every cycle.
  - rise = `clean_in & ~in_q`; fall = `~clean_in & in_q`.
- One shared counter, wide enough for max(LONG_CYC, REP_CYC, GAP_CYC); saturates and never wraps.
- FSM states: IDLE, PRESSED, LONG, plus WAIT_GAP and SWALLOW with the macro.
  - IDLE: on rise, pulse `press_out`, clear the counter, go to PRESSED.
  - PRESSED: count each cycle.
    - On fall: pulse `release_out`. Without the macro, also pulse `short_out` and go to IDLE. With the macro, go to WAIT_GAP.
    - Else, when the count reaches LONG_CYC: pulse `long_out`, clear the counter, go to LONG.
  - LONG: count each cycle.
    - Each time the count reaches REP_CYC: pulse `repeat_out` and clear the counter.
    - On fall: pulse `release_out`, go to IDLE. No `short_out`.
- Fall and a threshold on the same cycle: fall wins; no `long_out`/`repeat_out` that cycle.
- Output pulses are registered. Every output is deasserted in the cycle after its single assertion.
- `held_out` equals `in_q`.
- Reset (async, any state): FSM goes to IDLE; counter, `in_q` and all outputs go to 0.
  - A button already held at reset release produces `press_out` one cycle later and starts timing normally.
  - Events in flight are dropped; no pulse is emitted for them.

## Timing
- Let edge k be the first rising clk_in edge that samples `clean_in` = 1. `press_out` is high from edge k to k+1; `held_out` also rises at edge k.
- `long_out` is high for the one cycle starting at edge k+LONG_CYC, provided `clean_in` stays 1 through edge k+LONG_CYC.
- The n-th `repeat_out` is high from edge k+LONG_CYC+n·REP_CYC.
- `release_out` is high for the cycle starting at the first edge that samples `clean_in` = 0. Without the macro, `short_out` is high in that same cycle.
- Minimum input pulse: one cycle high or low. Every edge is seen and is never merged.

## Configuration
- Macro: `BUTTON_EVENT_DOUBLE_CLICK_EN`.
- Defined: WAIT_GAP and SWALLOW exist.
  - A release from PRESSED clears the counter and enters WAIT_GAP.
  - In WAIT_GAP, a rise before the count reaches GAP_CYC: pulse `press_out` and `double_out` together, go to SWALLOW.
  - If the count reaches GAP_CYC first: pulse `short_out`, go to IDLE. A rise on that same cycle counts as the double click.
  - SWALLOW: no `short_out`/`long_out`/`repeat_out`. On fall, pulse `release_out` and go to IDLE.
  - A release from LONG still goes directly to IDLE.
- Undefined: `double_out` is constant 0; `short_out` fires on release with zero added delay; no gap counter logic.

## Test plan
Common parameters: CLK_PERIOD_NS=1_000_000, LONG_PRESS_MS=8, REPEAT_PERIOD_MS=3, DOUBLE_GAP_MS=5.
- Short click: hold `clean_in` high for 4 cycles.
  - Macro off: `press_out` at k; `release_out` and `short_out` at k+4; no `long_out`.
  - Macro on: `short_out` at k+4+5.
- Long hold: hold high for 15 cycles, then release.
  - `long_out` at k+8; `repeat_out` at k+11 and k+14; `release_out` at k+15; no `short_out`.
- Boundary: `clean_in` falls so that the fall is first sampled at edge k+8.
  - `release_out` and `short_out` (macro off) at k+8; `long_out` never fires.
- Double click (macro on): high 2 cycles, low 3, high 2.
  - `double_out` coincides with the second `press_out`; no `short_out`, `long_out` or `repeat_out` anywhere.
- Reset mid-hold: assert `rst_n_in` = 0 at k+5 while held; deassert 2 cycles later with `clean_in` still 1.
  - All outputs are 0 immediately; `press_out` fires 1 cycle after deassertion; `long_out` fires 8 cycles after that `press_out`.

Source files
------------

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/short/long/repeat pulses.
// Define BUTTON_EVENT_DOUBLE_CLICK_EN to add double-click detection (WAIT_GAP/SWALLOW states).
module button_event_decoder #(
    parameter int CLK_PERIOD_NS    = 10,
    parameter int LONG_PRESS_MS    = 1000,
    parameter int REPEAT_PERIOD_MS = 100,
    parameter int DOUBLE_GAP_MS    = 250
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clean_in,
    output logic press_out,
    output logic release_out,
    output logic short_out,
    output logic long_out,
    output logic repeat_out,
    output logic double_out,
    output logic held_out
);
    localparam longint LONG_CYC = longint'(LONG_PRESS_MS) * 1_000_000 / CLK_PERIOD_NS;
    localparam longint REP_CYC  = longint'(REPEAT_PERIOD_MS) * 1_000_000 / CLK_PERIOD_NS;
    localparam longint GAP_CYC  = longint'(DOUBLE_GAP_MS) * 1_000_000 / CLK_PERIOD_NS;
    localparam longint MAX_LR   = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
    localparam longint MAX_CYC  = (MAX_LR > GAP_CYC) ? MAX_LR : GAP_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);
    // Thresholds compare against N-1 so the pulse registers exactly N edges after the clear.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    typedef enum logic [2:0] {IDLE, PRESSED, LONG, WAIT_GAP, SWALLOW} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
`endif

    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic in_q, rise, fall;
    logic press_d, release_d, short_d, long_d, repeat_d, double_d;

    assign rise     = clean_in & ~in_q;
    assign fall     = ~clean_in & in_q;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign held_out = in_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            cnt         <= '0;
            in_q        <= 1'b0;
            press_out   <= 1'b0;
            release_out <= 1'b0;
            short_out   <= 1'b0;
            long_out    <= 1'b0;
            repeat_out  <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            in_q        <= clean_in;
            press_out   <= press_d;
            release_out <= release_d;
            short_out   <= short_d;
            long_out    <= long_d;
            repeat_out  <= repeat_d;
        end
    end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) double_out <= 1'b0;
        else           double_out <= double_d;
    end
`else
    assign double_out = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        double_d  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
                    cnt_d     = '0;
                    state_d   = WAIT_GAP;
`else
                    short_d   = 1'b1;
                    state_d   = IDLE;
`endif
                end else if (cnt == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
            // A rise on the gap-expiry cycle still counts as the second click.
            WAIT_GAP: begin
                if (rise) begin
                    press_d  = 1'b1;
                    double_d = 1'b1;
                    state_d  = SWALLOW;
                end else if (cnt == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SWALLOW: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed cycle-by-cycle checks of all event pulses.
module tb_button_event_decoder;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic clean_in = 1'b0;
    logic press_out, release_out, short_out, long_out, repeat_out, double_out, held_out;
    logic [6:0] outs;
    int checks = 0;
    int errors = 0;

    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] P  = 7'b1000000;
    localparam logic [6:0] R  = 7'b0100000;
    localparam logic [6:0] S  = 7'b0010000;
    localparam logic [6:0] L  = 7'b0001000;
    localparam logic [6:0] RP = 7'b0000100;
    localparam logic [6:0] D  = 7'b0000010;
    localparam logic [6:0] H  = 7'b0000001;

    button_event_decoder #(
        .CLK_PERIOD_NS(1_000_000),
        .LONG_PRESS_MS(8),
        .REPEAT_PERIOD_MS(3),
        .DOUBLE_GAP_MS(5)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .clean_in(clean_in),
        .press_out(press_out),
        .release_out(release_out),
        .short_out(short_out),
        .long_out(long_out),
        .repeat_out(repeat_out),
        .double_out(double_out),
        .held_out(held_out)
    );

    always #5 clk_in = ~clk_in;
    assign outs = {press_out, release_out, short_out, long_out, repeat_out, double_out, held_out};

    task automatic chk(input string tag, input logic [6:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    task automatic run(input logic c, input logic [6:0] exp, input string tag);
        clean_in = c;
        @(posedge clk_in);
        #1;
        chk(tag, exp);
    endtask

    initial begin
        #2;
        chk("reset", Z);
        @(posedge clk_in);
        #1;
        chk("reset_held", Z);
        rst_n_in = 1'b1;
        run(0, Z, "idle");
        // Short click: 4 cycles high.
        run(1, P | H, "short_press");
        for (int i = 1; i < 4; i++) run(1, H, "short_hold");
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
        run(0, R, "short_release");
        for (int i = 5; i < 9; i++) run(0, Z, "short_gap");
        run(0, S, "short_late");
`else
        run(0, R | S, "short_release");
`endif
        for (int i = 0; i < 3; i++) run(0, Z, "short_after");
        // Long hold: 15 cycles high.
        run(1, P | H, "long_press");
        for (int i = 1; i < 8; i++) run(1, H, "long_hold");
        run(1, L | H, "long_pulse");
        run(1, H, "long_h9");
        run(1, H, "long_h10");
        run(1, RP | H, "repeat1");
        run(1, H, "long_h12");
        run(1, H, "long_h13");
        run(1, RP | H, "repeat2");
        run(0, R, "long_release");
        for (int i = 0; i < 8; i++) run(0, Z, "long_after");
        // Boundary: fall sampled on the long threshold edge.
        run(1, P | H, "bnd_press");
        for (int i = 1; i < 8; i++) run(1, H, "bnd_hold");
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
        run(0, R, "bnd_release");
        for (int i = 0; i < 4; i++) run(0, Z, "bnd_gap");
        run(0, S, "bnd_short");
`else
        run(0, R | S, "bnd_release");
        for (int i = 0; i < 5; i++) run(0, Z, "bnd_after");
`endif
        // Double click: high 2, low 3, high 2.
        run(1, P | H, "dbl_press1");
        run(1, H, "dbl_hold1");
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
        run(0, R, "dbl_release1");
        run(0, Z, "dbl_gap");
        run(0, Z, "dbl_gap");
        run(1, P | D | H, "dbl_press2");
        run(1, H, "dbl_hold2");
        run(0, R, "dbl_release2");
`else
        run(0, R | S, "dbl_release1");
        run(0, Z, "dbl_gap");
        run(0, Z, "dbl_gap");
        run(1, P | H, "dbl_press2");
        run(1, H, "dbl_hold2");
        run(0, R | S, "dbl_release2");
`endif
        for (int i = 0; i < 8; i++) run(0, Z, "dbl_after");
        // Reset mid-hold.
        run(1, P | H, "rst_press");
        for (int i = 1; i < 6; i++) run(1, H, "rst_hold");
        rst_n_in = 1'b0;
        #1;
        chk("rst_async", Z);
        @(posedge clk_in);
        #1;
        chk("rst_in1", Z);
        @(posedge clk_in);
        #1;
        chk("rst_in2", Z);
        rst_n_in = 1'b1;
        run(1, P | H, "rst_repress");
        for (int i = 1; i < 8; i++) run(1, H, "rst_rehold");
        run(1, L | H, "rst_long");
        run(0, R, "rst_release");
        run(0, Z, "rst_after");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
